// File: rtl/armleocpu_regfile_ctrl.sv
// Register file access controller: zeroes all registers after reset or on request,
// arbitrates the write port between writeback and debug, and shares the rs1 read port.
module armleocpu_regfile_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        clear_req,
    output logic        ctrl_ready,

    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_wdata,

    input  logic        dbg_wvalid,
    output logic        dbg_wready,
    input  logic [4:0]  dbg_waddr,
    input  logic [31:0] dbg_wdata,

    input  logic        dbg_rvalid,
    output logic        dbg_rready,
    input  logic [4:0]  dbg_raddr,
    output logic        dbg_rdata_valid,
    output logic [31:0] dbg_rdata,

    input  logic        dec_rs1_read,
    input  logic [4:0]  dec_rs1_addr,

    output logic        rf_rs1_read,
    output logic [4:0]  rf_rs1_addr,
    input  logic [31:0] rf_rs1_rdata,

    output logic        rf_rd_write,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd_wdata,
    output logic        rf_rst_n
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [3:0]  sc, sc_nxt;
    logic        forced;
    logic        wb_grant;
    logic        dbg_grant;
    logic        dbg_rd_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= CLEAR;
            cnt             <= '0;
            sc              <= '0;
            dbg_rdata_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            sc              <= sc_nxt;
            dbg_rdata_valid <= dbg_rd_fire;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        sc_nxt      = '0;
        ctrl_ready  = 1'b0;
        wb_ready    = 1'b0;
        dbg_wready  = 1'b0;
        dbg_rready  = 1'b0;
        rf_rs1_read = 1'b0;
        rf_rs1_addr = '0;
        rf_rd_write = 1'b0;
        rf_rd_addr  = '0;
        rf_rd_wdata = '0;
        rf_rst_n    = 1'b1;
        forced      = 1'b0;
        wb_grant    = 1'b0;
        dbg_grant   = 1'b0;
        dbg_rd_fire = 1'b0;

        case (state)
            CLEAR: begin
                // Step 0 resets the file (zeroing x0); steps 1..31 write zero to xk.
                rf_rst_n    = (cnt != 5'd0);
                rf_rd_write = (cnt != 5'd0);
                rf_rd_addr  = cnt;
                cnt_nxt     = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                ctrl_ready = 1'b1;

                forced     = (sc == 4'(STARVE_LIMIT));
                wb_ready   = !forced;
                dbg_wready = forced || !wb_valid;
                wb_grant   = wb_valid && wb_ready;
                dbg_grant  = dbg_wvalid && dbg_wready;

                if (wb_grant) begin
                    rf_rd_write = 1'b1;
                    rf_rd_addr  = wb_addr;
                    rf_rd_wdata = wb_wdata;
                end else if (dbg_grant) begin
                    rf_rd_write = 1'b1;
                    rf_rd_addr  = dbg_waddr;
                    rf_rd_wdata = dbg_wdata;
                end

                // Count consecutive losses of a pending debug write to writeback.
                if (!dbg_wvalid || dbg_grant) begin
                    sc_nxt = '0;
                end else if (wb_valid && wb_grant) begin
                    sc_nxt = sc + 4'd1;
                end else begin
                    sc_nxt = sc;
                end

                if (dec_rs1_read) begin
                    rf_rs1_read = 1'b1;
                    rf_rs1_addr = dec_rs1_addr;
                end else begin
                    dbg_rready  = 1'b1;
                    rf_rs1_read = dbg_rvalid;
                    rf_rs1_addr = dbg_raddr;
                    dbg_rd_fire = dbg_rvalid;
                end

                if (clear_req) begin
                    state_nxt = CLEAR;
                end
            end

            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign dbg_rdata = rf_rs1_rdata;

endmodule

// File: doc/armleocpu_regfile_ctrl.md
# armleocpu_regfile_ctrl

Access controller for the dual-read, single-write CPU register file. It owns the register file's write port, rs1 read port, and write-port reset line. It zeroes all 32 registers after reset or on request, and arbitrates the write port between pipeline writeback and the debug module with a starvation guard. It also shares the rs1 read port between decode and debug reads.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive cycles debug write may lose to writeback before being forced through (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  pulse: re-run register clear sequence
- ctrl_ready  out  1  1 = clear finished, normal operation
- wb_valid / wb_ready  in / out  1 / 1  writeback write handshake
- wb_addr, wb_wdata  in  5, 32  writeback destination and data
- dbg_wvalid / dbg_wready  in / out  1 / 1  debug write handshake
- dbg_waddr, dbg_wdata  in  5, 32  debug write destination and data
- dbg_rvalid / dbg_rready  in / out  1 / 1  debug read request handshake
- dbg_raddr  in  5  debug read address
- dbg_rdata_valid  out  1  dbg_rdata valid this cycle
- dbg_rdata  out  32  equals rf_rs1_rdata
- dec_rs1_read, dec_rs1_addr  in  1, 5  decode rs1 read request
- rf_rs1_read, rf_rs1_addr  out  1, 5  to register file rs1 port
- rf_rs1_rdata  in  32  from register file (1-cycle registered read)
- rf_rd_write, rf_rd_addr, rf_rd_wdata  out  1, 5, 32  to register file write port
- rf_rst_n  out  1  to register file active-low reset (forces x0 write of 0)

## Operation
- FSM states: CLEAR, RUN. rst → CLEAR, clear counter cnt=0.
- CLEAR, cycle k (k=0..31 after rst deassert):
  - k=0: rf_rst_n=0, rf_rd_write=0 (register file zeroes x0).
  - k=1..31: rf_rst_n=1, rf_rd_write=1, rf_rd_addr=k, rf_rd_wdata=0.
  - After k=31 → RUN.
  - During CLEAR: wb_ready, dbg_wready, dbg_rready, ctrl_ready = 0. rf_rs1_read=0. clear_req ignored.
- RUN: ctrl_ready=1, rf_rst_n=1. clear_req=1 → CLEAR with cnt=0 at next edge. Handshakes on that cycle complete normally.
- Write arbitration in RUN, with starve counter sc (reset 0):
  - Forced = (sc == STARVE_LIMIT).
  - wb_ready = !forced. dbg_wready = forced || !wb_valid. Readies do not depend on own valid.
  - Granted write drives rf_rd_write=1 with its addr/data; otherwise rf_rd_write=0.
  - sc update: sc+1 when wb_valid && dbg_wvalid && wb granted. sc=0 when a debug write is granted or dbg_wvalid=0.
- Writes to x0 are accepted and handshaked. The register file drops them.
- rs1 sharing in RUN:
  - dec_rs1_read=1: rf_rs1_read=1, rf_rs1_addr=dec_rs1_addr, dbg_rready=0.
  - Otherwise: dbg_rready=1. rf_rs1_read=dbg_rvalid, rf_rs1_addr=dbg_raddr.
- dbg_rdata_valid is registered: 1 the cycle after dbg_rvalid && dbg_rready.

## Timing
- Reset values: ctrl_ready=0, wb_ready=0, dbg_wready=0, dbg_rready=0, dbg_rdata_valid=0, rf_rd_write=0, rf_rs1_read=0, rf_rst_n=0, sc=0.
- Clear length: 32 cycles from first edge after rst deasserts. ctrl_ready rises on cycle 32.
- Write latency: register updated at the edge ending the handshake cycle.
- Read latency: data one cycle after the read cycle.
- Same-cycle read and write of one address returns the old value.
- rst asserted mid-clear or mid-transfer aborts everything. The clear restarts from k=0.

## Test plan
- Reset release: rst low at t0 → rf_rst_n=0 for cycle 0, then writes x1..x31=0. ctrl_ready=1 at cycle 32. Debug reads of x0..x31 all return 0.
- Writeback only: wb write x5=0xDEADBEEF → next-cycle debug read of x5 returns 0xDEADBEEF, with dbg_rdata_valid one cycle after accept.
- Starvation (STARVE_LIMIT=4): wb_valid and dbg_wvalid held high → wb granted 4 cycles, cycle 5 dbg granted with wb_ready=0, then pattern repeats.
- Read sharing: dec_rs1_read=1 with dbg_rvalid=1 → dbg_rready=0. Drop dec_rs1_read → dbg read accepted, data next cycle.
- x0 protection: wb write x0=0x12345678 → handshake completes, x0 reads 0.
- clear_req in RUN after writing x7=0x55 → ctrl_ready drops next cycle. After 32 cycles x7 reads 0. A clear_req during CLEAR does not extend the sequence.
